key_input_conditioner: RTL and testbench



---
 rtl/game_pkg.sv | 24 ++
 rtl/key_debounce_channel.sv | 141 ++++++++++++++
 rtl/key_input_conditioner.sv | 67 ++++++
 tb/tb_key_input_conditioner.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
//   Shared definitions for the push-button front end of the game controller.
//   - key_state_e : per-channel debounce FSM state encoding (2 bits)
//   - KEY_*       : bit positions of the controller inputs on the key bus
//   - DEBOUNCE_SIM: short debounce length used by simulation benches
// ---------------------------------------------------------------------------
package game_pkg;

   typedef enum logic [1:0] {
      IDLE_UP   = 2'd0,
      WAIT_DOWN = 2'd1,
      HELD_DOWN = 2'd2,
      WAIT_UP   = 2'd3
   } key_state_e;

   localparam int unsigned KEY_SEL1 = 32'd0;
   localparam int unsigned KEY_SEL2 = 32'd1;
   localparam int unsigned KEY_SEL3 = 32'd2;
   localparam int unsigned KEY_GO   = 32'd3;

   localparam int unsigned DEBOUNCE_SIM = 32'd8;

endpackage : game_pkg

// File: rtl/key_debounce_channel.sv
// ---------------------------------------------------------------------------
// key_debounce_channel
//   One key: 2-flop synchronizer, counter-based debouncer and registered
//   press/release pulse generation.
//
//   Ports:
//     clk       in   system clock
//     resetn    in   asynchronous active-low reset
//     raw_i     in   unsynchronized pin (pressed level set by ACTIVE_LOW)
//     level_o   out  debounced level, 1 = pressed (registered)
//     press_o   out  one-cycle pulse on an accepted press (registered)
//     release_o out  one-cycle pulse on an accepted release (registered)
// ---------------------------------------------------------------------------
module key_debounce_channel
   import game_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 32'd500000,
   parameter int unsigned CNT_W           = 32'd19,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic resetn,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic             IDLE_RAW = logic'(ACTIVE_LOW);

   logic             sync1_q;
   logic             sync2_q;
   logic             pressed_s;
   key_state_e       state_q;
   key_state_e       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             level_q;
   logic             level_d;
   logic             press_q;
   logic             press_d;
   logic             release_q;
   logic             release_d;

   // Synchronizer: the raw pin is synchronized as-is so that the flops
   // reset to the idle pin level; polarity is normalised after sync2.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1_q <= IDLE_RAW;
         sync2_q <= IDLE_RAW;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
      end
   end

   // 1 = pressed, independent of pin polarity.
   assign pressed_s = sync2_q ^ IDLE_RAW;

   // State, counter and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE_UP;
         cnt_q     <= CNT_ZERO;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   // Next-state and next-output logic. The counter only increments while
   // below CNT_MAX, so it saturates rather than wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE_UP: begin
            if (pressed_s) begin
               state_d = WAIT_DOWN;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = CNT_ZERO;
            end
         end
         WAIT_DOWN: begin
            if (!pressed_s) begin
               state_d = IDLE_UP;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_MAX) begin
               state_d = HELD_DOWN;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         HELD_DOWN: begin
            if (!pressed_s) begin
               state_d = WAIT_UP;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = CNT_ZERO;
            end
         end
         WAIT_UP: begin
            if (pressed_s) begin
               state_d = HELD_DOWN;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE_UP;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE_UP;
            cnt_d   = CNT_ZERO;
         end
      endcase

      // Outputs are computed from the next state so that level and pulse
      // update on the same edge as the accepting transition.
      level_d   = (state_d == HELD_DOWN) || (state_d == WAIT_UP);
      press_d   = (state_q == WAIT_DOWN) && (state_d == HELD_DOWN);
      release_d = (state_q == WAIT_UP)   && (state_d == IDLE_UP);
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule : key_debounce_channel

// File: rtl/key_input_conditioner.sv
// ---------------------------------------------------------------------------
// key_input_conditioner
//   Conditions the raw DE1 buttons/switches for the game controller:
//   one key_debounce_channel per key plus a lowest-index press encoder.
//
//   Ports:
//     clk          in   system clock, 50 MHz
//     resetn       in   asynchronous active-low reset
//     raw_key      in   unsynchronized pins (bit 0 select1 .. bit 3 go)
//     key_level    out  debounced levels, 1 = pressed
//     key_press    out  one-cycle pulse per accepted press
//     key_release  out  one-cycle pulse per accepted release
//     any_press    out  OR of key_press
//     press_idx    out  lowest set index of key_press, 0 when none
// ---------------------------------------------------------------------------
module key_input_conditioner
   import game_pkg::*;
#(
   parameter int unsigned NUM_KEYS        = 32'd4,
   parameter int unsigned DEBOUNCE_CYCLES = 32'd500000,
   parameter int unsigned CNT_W           = 32'd19,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [NUM_KEYS-1:0] raw_key,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic                any_press,
   output logic [1:0]          press_idx
);

   logic [1:0] press_idx_s;

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
      key_debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_chan (
         .clk       (clk),
         .resetn    (resetn),
         .raw_i     (raw_key[g]),
         .level_o   (key_level[g]),
         .press_o   (key_press[g]),
         .release_o (key_release[g])
      );
   end

   // Lowest-index encoder over the registered pulses: scanning from the top
   // down lets the lowest set bit overwrite any higher one.
   always_comb begin
      press_idx_s = 2'd0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (key_press[i]) begin
            press_idx_s = 2'(i);
         end else begin
            press_idx_s = press_idx_s;
         end
      end
   end

   assign any_press = |key_press;
   assign press_idx = press_idx_s;

endmodule : key_input_conditioner

// File: tb/tb_key_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_key_input_conditioner
//   Directed bench for key_input_conditioner (DEBOUNCE_CYCLES = DEBOUNCE_SIM)
//   plus a second instance with DEBOUNCE_CYCLES = 1.
//   Cycle c = the c-th rising edge after the stimulus is applied; outputs are
//   sampled 1 time unit after that edge.
// ---------------------------------------------------------------------------
module tb_key_input_conditioner;
   import game_pkg::*;

   logic       clk;
   logic       resetn;
   logic [3:0] raw_key;
   logic [3:0] key_level;
   logic [3:0] key_press;
   logic [3:0] key_release;
   logic       any_press;
   logic [1:0] press_idx;

   logic [3:0] raw_f;
   logic [3:0] level_f;
   logic [3:0] press_f;
   logic [3:0] release_f;
   logic       any_f;
   logic [1:0] idx_f;

   int n_tests;
   int n_fail;

   int press_n [4];
   int press_at[4];
   int rel_n   [4];
   int rel_at  [4];

   key_input_conditioner #(
      .NUM_KEYS        (4),
      .DEBOUNCE_CYCLES (DEBOUNCE_SIM),
      .CNT_W           (19),
      .ACTIVE_LOW      (1'b1)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .raw_key     (raw_key),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .any_press   (any_press),
      .press_idx   (press_idx)
   );

   key_input_conditioner #(
      .NUM_KEYS        (4),
      .DEBOUNCE_CYCLES (1),
      .CNT_W           (19),
      .ACTIVE_LOW      (1'b1)
   ) dut_fast (
      .clk         (clk),
      .resetn      (resetn),
      .raw_key     (raw_f),
      .key_level   (level_f),
      .key_press   (press_f),
      .key_release (release_f),
      .any_press   (any_f),
      .press_idx   (idx_f)
   );

   // 100 MHz-style free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_tally();
      for (int k = 0; k < 4; k++) begin
         press_n[k]  = 0;
         press_at[k] = -1;
         rel_n[k]    = 0;
         rel_at[k]   = -1;
      end
   endtask

   task automatic sample(input int c);
      for (int k = 0; k < 4; k++) begin
         if (key_press[k] === 1'b1) begin
            if (press_n[k] == 0) press_at[k] = c;
            press_n[k]++;
         end
         if (key_release[k] === 1'b1) begin
            if (rel_n[k] == 0) rel_at[k] = c;
            rel_n[k]++;
         end
      end
   endtask

   initial begin
      int lvl_early;
      int nonzero;

      n_tests = 0;
      n_fail  = 0;
      resetn  = 1'b1;
      raw_key = 4'b1111;
      raw_f   = 4'b1111;

      // ---------------- reset ----------------
      #3 resetn = 1'b0;
      #1;
      check_eq("rst_level",   32'(key_level),   32'h0);
      check_eq("rst_press",   32'(key_press),   32'h0);
      check_eq("rst_release", 32'(key_release), 32'h0);
      check_eq("rst_any",     32'(any_press),   32'h0);
      check_eq("rst_idx",     32'(press_idx),   32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      repeat (5) @(posedge clk);

      // ---------------- clean press + release on key 0 ----------------
      clear_tally();
      @(negedge clk) raw_key = 4'b1110;
      for (int c = 0; c < 70; c++) begin
         @(posedge clk); #1;
         sample(c);
         if (c == 9) begin
            check_eq("clean_lvl_c9", 32'(key_level[KEY_SEL1]), 32'h0);
            check_eq("clean_any_c9", 32'(any_press), 32'h0);
         end
         if (c == 10) begin
            check_eq("clean_lvl_c10",   32'(key_level), 32'h1);
            check_eq("clean_press_c10", 32'(key_press), 32'h1);
            check_eq("clean_any_c10",   32'(any_press), 32'h1);
            check_eq("clean_idx_c10",   32'(press_idx), 32'h0);
         end
         if (c == 59) check_eq("rel_lvl_c59", 32'(key_level[KEY_SEL1]), 32'h1);
         if (c == 60) begin
            check_eq("rel_lvl_c60",  32'(key_level[KEY_SEL1]), 32'h0);
            check_eq("rel_pulse_c60", 32'(key_release), 32'h1);
         end
         if (c == 49) raw_key = 4'b1111;
      end
      check_eq("clean_press_count", 32'(press_n[0]), 32'd1);
      check_eq("clean_press_cycle", 32'(press_at[0]), 32'd10);
      check_eq("rel_count",         32'(rel_n[0]), 32'd1);
      check_eq("rel_cycle",         32'(rel_at[0]), 32'd60);
      repeat (5) @(posedge clk);

      // ---------------- simultaneous press on keys 1 and 3 ----------------
      clear_tally();
      @(negedge clk) raw_key = 4'b0101;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         sample(c);
         if (c == 10) begin
            check_eq("sim_press_c10", 32'(key_press), 32'ha);
            check_eq("sim_any_c10",   32'(any_press), 32'h1);
            check_eq("sim_idx_c10",   32'(press_idx), 32'h1);
         end
      end
      check_eq("sim_cnt_k1", 32'(press_n[KEY_SEL2]), 32'd1);
      check_eq("sim_cnt_k3", 32'(press_n[KEY_GO]),   32'd1);
      @(negedge clk) raw_key = 4'b1111;
      repeat (20) @(posedge clk);

      // ---------------- bounce on key 2 ----------------
      clear_tally();
      lvl_early = 0;
      @(negedge clk) raw_key = 4'b1011;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         sample(c);
         if (c < 17 && key_level[KEY_SEL3] !== 1'b0) lvl_early++;
         if (c + 1 == 5 || c + 1 == 6) raw_key = 4'b1111;
         else                          raw_key = 4'b1011;
      end
      check_eq("bounce_press_count", 32'(press_n[KEY_SEL3]), 32'd1);
      check_eq("bounce_press_cycle", 32'(press_at[KEY_SEL3]), 32'd17);
      check_eq("bounce_early_level", 32'(lvl_early), 32'd0);
      @(negedge clk) raw_key = 4'b1111;
      repeat (20) @(posedge clk);

      // ---------------- asynchronous reset while a key is held ----------------
      @(negedge clk) raw_key = 4'b1110;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         if (c == 14) check_eq("held_before_rst", 32'(key_level), 32'h1);
      end
      resetn = 1'b0;
      #2;
      check_eq("async_rst_level", 32'(key_level), 32'h0);
      check_eq("async_rst_any",   32'(any_press), 32'h0);
      raw_key = 4'b1111;
      repeat (3) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      nonzero = 0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk); #1;
         if ((key_level | key_press | key_release) !== 4'b0000 || any_press !== 1'b0)
            nonzero++;
      end
      check_eq("idle_after_rst_quiet", 32'(nonzero), 32'd0);

      // ---------------- reset during debounce on key 3 ----------------
      clear_tally();
      @(negedge clk) raw_key = 4'b0111;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         sample(c);
         if (c == 4) resetn = 1'b0;
         if (c == 5) resetn = 1'b1;
      end
      check_eq("rstdb_press_count", 32'(press_n[KEY_GO]),  32'd1);
      check_eq("rstdb_press_cycle", 32'(press_at[KEY_GO]), 32'd16);
      @(negedge clk) raw_key = 4'b1111;
      repeat (20) @(posedge clk);

      // ---------------- DEBOUNCE_CYCLES = 1 on key 2 ----------------
      @(negedge clk) raw_f = 4'b1011;
      for (int c = 0; c < 14; c++) begin
         @(posedge clk); #1;
         if (c == 2) check_eq("fast_press_c2", 32'(press_f), 32'h0);
         if (c == 3) begin
            check_eq("fast_press_c3", 32'(press_f), 32'h4);
            check_eq("fast_lvl_c3",   32'(level_f), 32'h4);
            check_eq("fast_any_c3",   32'(any_f),   32'h1);
            check_eq("fast_idx_c3",   32'(idx_f),   32'h2);
         end
         if (c == 4) check_eq("fast_press_c4", 32'(press_f), 32'h0);
         if (c == 9) begin
            check_eq("fast_rel_c9", 32'(release_f), 32'h4);
            check_eq("fast_lvl_c9", 32'(level_f),   32'h0);
         end
         if (c == 5) raw_f = 4'b1111;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_key_input_conditioner
